// File: rtl/add_seq_pkg.sv
// Shared definitions for the multi-precision adder sequencer: FSM state
// encoding, slice width, result flag bundle and the index-width helper.
package add_seq_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic sign;
    logic zero;
    logic carry;
    logic parity;
    logic overflow;
  } flags_t;

  // Width of the slice index counter: clog2(words), never less than one bit
  function automatic int idxWidth(input int words);
    int w;
    w = 1;
    while ((1 << w) < words) w++;
    return w;
  endfunction

endpackage

// File: rtl/add16_cin.sv
// 16-bit carry-lookahead adder slice with carry-in, built from four 4-bit
// lookahead groups plus a second-level lookahead unit across the groups.
module add16_cin (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        cin,
  output logic [15:0] z,
  output logic        cout
);

  logic [15:0] p;
  logic [15:0] g;
  logic [15:0] c;
  logic [3:0]  gp;
  logic [3:0]  gg;
  logic [4:0]  gc;

  assign p = x ^ y;
  assign g = x & y;

  genvar k;
  generate
    for (k = 0; k < 4; k++) begin : gGroup
      // Group propagate/generate, then bit carries from the group carry-in
      assign gp[k] = &p[4*k +: 4];
      assign gg[k] = g[4*k+3]
                   | (p[4*k+3] & g[4*k+2])
                   | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                   | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      assign c[4*k]   = gc[k];
      assign c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      assign c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                      | (p[4*k+1] & p[4*k] & gc[k]);
      assign c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                      | (p[4*k+2] & p[4*k+1] & g[4*k])
                      | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
  endgenerate

  // Second-level lookahead: every group carry-in straight from cin
  assign gc[0] = cin;
  assign gc[1] = gg[0] | (gp[0] & cin);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & cin);
  assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0])
               | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

  assign z    = p ^ c;
  assign cout = gc[4];

endmodule

// File: rtl/add_seq_ctrl.sv
// Multi-precision adder sequencer: adds two WORDS x 16-bit operands through
// one shared 16-bit CLA slice, least significant word first, chaining the
// carry through a register. Produces sum plus sign/zero/carry/parity/overflow.
// Optional subtraction is enabled by defining the macro SUB_ADD_EN.
module add_seq_ctrl
  import add_seq_pkg::*;
#(
  parameter int WORDS = 2,
  localparam int W = SLICE_W * WORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         sign,
  output logic         zero,
  output logic         carry,
  output logic         parity,
  output logic         overflow,
  output logic         busy
);

  localparam int IW = idxWidth(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   sum_q, sum_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           creg_q, creg_d;
  logic           zacc_q, zacc_d;
  flags_t         flags_q, flags_d;

  logic           subEff;
  logic [15:0]    sliceX;
  logic [15:0]    sliceY;
  logic [15:0]    sliceZ;
  logic           sliceCout;
  logic [W-1:0]   sumNext;

`ifdef SUB_ADD_EN
  assign subEff = sub;
`else
  logic unusedSub;
  assign unusedSub = sub;
  assign subEff    = 1'b0;
`endif

  assign sliceX = a_q[int'(idx_q) * SLICE_W +: SLICE_W];
  assign sliceY = b_q[int'(idx_q) * SLICE_W +: SLICE_W];

  add16_cin uSlice (
    .x    (sliceX),
    .y    (sliceY),
    .cin  (creg_q),
    .z    (sliceZ),
    .cout (sliceCout)
  );

  // Sum as it will look once the current slice result is written back
  always_comb begin
    sumNext = sum_q;
    sumNext[int'(idx_q) * SLICE_W +: SLICE_W] = sliceZ;
  end

  // Next-state logic: accept in IDLE, one slice per cycle in RUN, hold in DONE
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    creg_d  = creg_q;
    zacc_d  = zacc_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = subEff ? ~b : b;
          creg_d  = subEff;
          idx_d   = '0;
          zacc_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d  = sumNext;
        creg_d = sliceCout;
        zacc_d = zacc_q & (sliceZ == 16'h0000);
        if (idx_q == LAST) begin
          flags_d.sign     = sumNext[W-1];
          flags_d.zero     = zacc_q & (sliceZ == 16'h0000);
          flags_d.carry    = sliceCout;
          flags_d.parity   = ~^sumNext;
          flags_d.overflow = (a_q[W-1] & b_q[W-1] & ~sumNext[W-1])
                           | (~a_q[W-1] & ~b_q[W-1] & sumNext[W-1]);
          state_d          = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      creg_q  <= 1'b0;
      zacc_q  <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      creg_q  <= creg_d;
      zacc_q  <= zacc_d;
      flags_q <= flags_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign sign      = flags_q.sign;
  assign zero      = flags_q.zero;
  assign carry     = flags_q.carry;
  assign parity    = flags_q.parity;
  assign overflow  = flags_q.overflow;

endmodule
